// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart_tx serialiser: buffers CPU writes and launches
// one byte per tx_dv pulse, waiting for tx_done before the next launch.
module uart_tx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr_ovf,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              launch;
    logic              push;
    logic              drop;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        mem [DEPTH];

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    assign push  = wr_en && !full;
    assign drop  = wr_en && full;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_active) begin
                    launch    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage array carries no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            tx_dv <= launch;
            if (launch) begin
                tx_byte <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            case ({push, launch})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            // Set-dominant: a drop in the same cycle as clr_ovf keeps the flag.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, fill/overflow, pop-vs-full write,
// pointer wrap ordering, reset with serialiser busy, and overflow clearing.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    // Wait for a launch, check its byte and the count at launch, then
    // complete it with tx_done (optionally pushing a byte in that cycle).
    task automatic send_one(input logic [7:0] exp, input logic [4:0] exp_cnt,
                            input logic do_wr, input logic [7:0] wd);
        int n = 0;
        while (!tx_dv && n < 20) begin
            step();
            n++;
        end
        chk("launch_seen", tx_dv, 1);
        chk("tx_byte", tx_byte, exp);
        chk("count_at_launch", count, exp_cnt);
        step();
        chk("dv_one_cycle", tx_dv, 0);
        tx_done = 1'b1;
        wr_en   = do_wr;
        wr_data = wd;
        step();
        tx_done = 1'b0;
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        tx_active = 1'b0; tx_done = 1'b0;
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dv", tx_dv, 0);
        chk("rst_byte", tx_byte, 8'h00);
        chk("rst_ovf", overflow, 0);

        // 1: single byte, two-edge latency
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("t1_no_fallthru", tx_dv, 0);
        chk("t1_count1", count, 1);
        step();
        chk("t1_dv", tx_dv, 1);
        chk("t1_byte", tx_byte, 8'hA5);
        chk("t1_count0", count, 0);
        chk("t1_empty", empty, 1);
        step();
        chk("t1_dv_low", tx_dv, 0);
        chk("t1_byte_held", tx_byte, 8'hA5);
        tx_done = 1'b1; step(); tx_done = 1'b0;

        // 2: fill with serialiser stalled, overflow, ordered drain
        tx_active = 1'b1;
        fill(8'h00, 16);
        chk("t2_full", full, 1);
        chk("t2_count16", count, 16);
        chk("t2_no_launch", tx_dv, 0);
        fill(8'hFF, 1);
        chk("t2_ovf", overflow, 1);
        chk("t2_count_kept", count, 16);
        tx_active = 1'b0;
        for (int i = 0; i < 16; i++) send_one(8'(i), 5'(15 - i), 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_no_extra", tx_dv, 0);
        end
        chk("t2_empty", empty, 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("t2_ovf_clr", overflow, 0);

        // 3: pop and write in the same cycle while full
        tx_active = 1'b1;
        fill(8'h20, 16);
        tx_active = 1'b0;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        chk("t3_dv", tx_dv, 1);
        chk("t3_count15", count, 15);
        chk("t3_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) send_one(8'h20 + 8'(i), 5'(15 - i), 1'b0, 8'h00);
        chk("t3_empty", empty, 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

        // 4: interleaved writes and pops, pointers wrap
        tx_active = 1'b1;
        fill(8'h40, 3);
        chk("t4_count3", count, 3);
        tx_active = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send_one(8'h40 + 8'(k), 5'd2, 1'b1, 8'h43 + 8'(k));
            chk("t4_count_after", count, 3);
        end
        for (int k = 0; k < 3; k++) send_one(8'h54 + 8'(k), 5'(2 - k), 1'b0, 8'h00);
        chk("t4_empty", empty, 1);
        chk("t4_no_ovf", overflow, 0);

        // 5: reset while BUSY with 5 queued and serialiser active
        fill(8'h60, 6);
        tx_active = 1'b1;
        chk("t5_count5", count, 5);
        do_reset();
        chk("t5_count0", count, 0);
        chk("t5_dv", tx_dv, 0);
        chk("t5_empty", empty, 1);
        chk("t5_byte", tx_byte, 8'h00);
        fill(8'h77, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_wait_active", tx_dv, 0);
        end
        chk("t5_count1", count, 1);
        tx_active = 1'b0;
        step();
        chk("t5_dv_launch", tx_dv, 1);
        chk("t5_byte77", tx_byte, 8'h77);
        step();
        tx_done = 1'b1; step(); tx_done = 1'b0;

        // 6: clr_ovf together with an overflowing write
        tx_active = 1'b1;
        fill(8'h80, 16);
        chk("t6_no_ovf", overflow, 0);
        wr_en = 1'b1; wr_data = 8'h99; clr_ovf = 1'b1;
        step();
        wr_en = 1'b0;
        chk("t6_set_dominant", overflow, 1);
        step();
        clr_ovf = 1'b0;
        chk("t6_cleared", overflow, 0);
        chk("t6_count16", count, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
